// File: rtl/regbank_access_arbiter.sv
// rtl/regbank_access_arbiter.sv - two-client arbiter serialising accesses onto a single-port register bank
// Define REGBANK_ARB_RR_EN for round-robin grant under contention; default is fixed priority to client 0.
module regbank_access_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REG = 6,
  localparam int SELECT_WIDTH = $clog2(NUM_REG)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [1:0]                          i_req_valid,
  output logic [1:0]                          o_req_ready,
  input  logic [1:0]                          i_req_write,
  input  logic [1:0][SELECT_WIDTH-1:0]        i_req_sel,
  input  logic [1:0][DATA_WIDTH-1:0]          i_req_wdata,
  output logic                                o_bank_we,
  output logic [SELECT_WIDTH-1:0]             o_bank_sel,
  output logic [DATA_WIDTH-1:0]               o_bank_wdata,
  input  logic [DATA_WIDTH-1:0]               i_bank_rdata,
  output logic                                o_rsp_valid,
  input  logic                                i_rsp_ready,
  output logic                                o_rsp_id,
  output logic [DATA_WIDTH-1:0]               o_rsp_data,
  output logic                                o_rsp_err
);

  localparam logic [SELECT_WIDTH:0] NUM_REG_W = NUM_REG[SELECT_WIDTH:0];

  logic                    cmd_valid;
  logic                    cmd_id;
  logic                    cmd_write;
  logic [SELECT_WIDTH-1:0] cmd_sel;
  logic [DATA_WIDTH-1:0]   cmd_wdata;

  logic                    rsp_valid;
  logic                    rsp_id;
  logic                    rsp_err;
  logic [DATA_WIDTH-1:0]   rsp_data;

  logic [1:0] grant;
  logic       cmd_adv;
  logic       cmd_free;
  logic       cmd_in_range;
  logic       accept;

`ifdef REGBANK_ARB_RR_EN
  logic last_served;

  always_comb begin
    grant = i_req_valid;
    if (i_req_valid == 2'b11) grant = last_served ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_served <= 1'b1;
    else if (accept) last_served <= grant[1];
  end
`else
  always_comb begin
    grant = i_req_valid;
    if (i_req_valid[0]) grant = 2'b01;
  end
`endif

  assign cmd_adv      = cmd_valid & (~rsp_valid | i_rsp_ready);
  assign cmd_free     = ~cmd_valid | cmd_adv;
  assign cmd_in_range = {1'b0, cmd_sel} < NUM_REG_W;

  // Ready is masked during reset so no handshake can complete while the pipeline is held clear.
  assign o_req_ready = grant & {2{cmd_free & rst_n}};
  assign accept      = |(i_req_valid & o_req_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_id    <= 1'b0;
      cmd_write <= 1'b0;
      cmd_sel   <= '0;
      cmd_wdata <= '0;
    end else if (accept) begin
      cmd_valid <= 1'b1;
      cmd_id    <= grant[1];
      cmd_write <= i_req_write[grant[1]];
      cmd_sel   <= i_req_sel[grant[1]];
      cmd_wdata <= i_req_wdata[grant[1]];
    end else if (cmd_adv) begin
      cmd_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else if (cmd_adv) begin
      rsp_valid <= 1'b1;
      rsp_id    <= cmd_id;
      rsp_err   <= ~cmd_in_range;
      rsp_data  <= (cmd_in_range & ~cmd_write) ? i_bank_rdata : '0;
    end else if (i_rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // The bank is touched only in the cycle the command retires, giving exactly one access per request.
  assign o_bank_we    = cmd_adv & cmd_write & cmd_in_range;
  assign o_bank_sel   = cmd_sel;
  assign o_bank_wdata = cmd_wdata;

  assign o_rsp_valid = rsp_valid;
  assign o_rsp_id    = rsp_id;
  assign o_rsp_err   = rsp_err;
  assign o_rsp_data  = rsp_data;

endmodule

// File: tb/tb_regbank_access_arbiter.sv
// tb/tb_regbank_access_arbiter.sv - directed table-driven bench for regbank_access_arbiter
module tb_regbank_access_arbiter;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      i_req_valid;
  logic [1:0]      o_req_ready;
  logic [1:0]      i_req_write;
  logic [1:0][2:0] i_req_sel;
  logic [1:0][7:0] i_req_wdata;
  logic            o_bank_we;
  logic [2:0]      o_bank_sel;
  logic [7:0]      o_bank_wdata;
  logic [7:0]      i_bank_rdata;
  logic            o_rsp_valid;
  logic            i_rsp_ready;
  logic            o_rsp_id;
  logic [7:0]      o_rsp_data;
  logic            o_rsp_err;

  int total = 0;
  int bad = 0;

  regbank_access_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_write(i_req_write), .i_req_sel(i_req_sel), .i_req_wdata(i_req_wdata),
    .o_bank_we(o_bank_we), .o_bank_sel(o_bank_sel), .o_bank_wdata(o_bank_wdata),
    .i_bank_rdata(i_bank_rdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_id(o_rsp_id), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err)
  );

  always #5 clk = ~clk;

  // Register bank model: combinational read, write at clock edge; out-of-range reads return junk.
  logic [7:0] bank [0:5] = '{default: 8'h00};
  int we_count = 0;
  assign i_bank_rdata = (o_bank_sel < 3'd6) ? bank[o_bank_sel] : 8'h5A;
  always @(posedge clk) begin
    if (o_bank_we) begin
      if (o_bank_sel < 3'd6) bank[o_bank_sel] <= o_bank_wdata;
      we_count <= we_count + 1;
    end
  end

  typedef struct {
    logic [1:0] valid;
    logic       write;
    logic [2:0] sel;
    logic [7:0] wd;
    logic [1:0] e_ready;
    logic       e_we;
    logic       e_rv;
    logic       e_id;
    logic [7:0] e_data;
    logic       e_err;
  } vec_t;

  vec_t tbl [0:21];

  function automatic vec_t mkv(input int c, input logic wr, input logic [2:0] sel, input logic [7:0] wd,
                               input logic [1:0] er, input logic ewe, input logic erv, input logic eid,
                               input logic [7:0] ed, input logic eerr);
    vec_t v;
    v.valid = (c == 0) ? 2'b01 : (c == 1) ? 2'b10 : 2'b00;
    v.write = wr; v.sel = sel; v.wd = wd;
    v.e_ready = er; v.e_we = ewe; v.e_rv = erv; v.e_id = eid; v.e_data = ed; v.e_err = eerr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] valid, input logic wr, input logic [2:0] sel, input logic [7:0] wd,
                       input logic rr);
    i_req_valid = valid;
    i_req_write = {wr, wr};
    i_req_sel   = {sel, sel};
    i_req_wdata = {wd, wd};
    i_rsp_ready = rr;
  endtask

  task automatic chk_rsp(input string nm, input logic id, input logic [7:0] d, input logic err);
    chk({nm, "_rv"}, {31'd0, o_rsp_valid}, 1);
    chk({nm, "_id"}, {31'd0, o_rsp_id}, {31'd0, id});
    chk({nm, "_data"}, {24'd0, o_rsp_data}, {24'd0, d});
    chk({nm, "_err"}, {31'd0, o_rsp_err}, {31'd0, err});
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ready"}, {30'd0, o_req_ready}, 0);
    chk({nm, "_we"}, {31'd0, o_bank_we}, 0);
    chk({nm, "_sel"}, {29'd0, o_bank_sel}, 0);
    chk({nm, "_wdata"}, {24'd0, o_bank_wdata}, 0);
    chk({nm, "_rv"}, {31'd0, o_rsp_valid}, 0);
    chk({nm, "_id"}, {31'd0, o_rsp_id}, 0);
    chk({nm, "_data"}, {24'd0, o_rsp_data}, 0);
    chk({nm, "_err"}, {31'd0, o_rsp_err}, 0);
  endtask

  task automatic step(input logic [1:0] valid, input logic wr, input logic [2:0] sel, input logic [7:0] wd,
                      input logic rr);
    @(posedge clk); #1;
    drive(valid, wr, sel, wd, rr);
    @(negedge clk);
  endtask

  task automatic reset_mid_cycle(input string nm);
    #1;
    rst_n = 1'b0;
    i_req_valid = 2'($urandom());
    i_req_write = 2'($urandom());
    i_req_sel   = 6'($urandom());
    i_req_wdata = 16'($urandom());
    i_rsp_ready = 1'($urandom());
    #1;
    chk_all_zero(nm);
    repeat (2) @(posedge clk);
    #1;
    drive(2'b00, 1'b0, 3'd0, 8'h00, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int we_base;
  logic [1:0] exp_rdy;
  logic exp_id [0:5];

  initial begin
    // Hand-computed cycle table: writeback/readback, out-of-range accesses, full-rate read sweep.
    tbl[0]  = mkv(0, 1, 3'd2, 8'hAA, 2'b01, 0, 0, 0, 8'h00, 0);
    tbl[1]  = mkv(0, 0, 3'd2, 8'h00, 2'b01, 1, 0, 0, 8'h00, 0);
    tbl[2]  = mkv(2, 0, 3'd0, 8'h00, 2'b00, 0, 1, 0, 8'h00, 0);
    tbl[3]  = mkv(2, 0, 3'd0, 8'h00, 2'b00, 0, 1, 0, 8'hAA, 0);
    tbl[4]  = mkv(2, 0, 3'd0, 8'h00, 2'b00, 0, 0, 0, 8'h00, 0);
    tbl[5]  = mkv(0, 1, 3'd7, 8'hCC, 2'b01, 0, 0, 0, 8'h00, 0);
    tbl[6]  = mkv(2, 0, 3'd0, 8'h00, 2'b00, 0, 0, 0, 8'h00, 0);
    tbl[7]  = mkv(2, 0, 3'd0, 8'h00, 2'b00, 0, 1, 0, 8'h00, 1);
    tbl[8]  = mkv(2, 0, 3'd0, 8'h00, 2'b00, 0, 0, 0, 8'h00, 0);
    tbl[9]  = mkv(1, 0, 3'd6, 8'h00, 2'b10, 0, 0, 0, 8'h00, 0);
    tbl[10] = mkv(2, 0, 3'd0, 8'h00, 2'b00, 0, 0, 0, 8'h00, 0);
    tbl[11] = mkv(2, 0, 3'd0, 8'h00, 2'b00, 0, 1, 1, 8'h00, 1);
    tbl[12] = mkv(2, 0, 3'd0, 8'h00, 2'b00, 0, 0, 0, 8'h00, 0);
    tbl[13] = mkv(0, 0, 3'd0, 8'h00, 2'b01, 0, 0, 0, 8'h00, 0);
    tbl[14] = mkv(0, 0, 3'd1, 8'h00, 2'b01, 0, 0, 0, 8'h00, 0);
    tbl[15] = mkv(0, 0, 3'd2, 8'h00, 2'b01, 0, 1, 0, 8'h00, 0);
    tbl[16] = mkv(0, 0, 3'd3, 8'h00, 2'b01, 0, 1, 0, 8'h00, 0);
    tbl[17] = mkv(0, 0, 3'd4, 8'h00, 2'b01, 0, 1, 0, 8'hAA, 0);
    tbl[18] = mkv(0, 0, 3'd5, 8'h00, 2'b01, 0, 1, 0, 8'h00, 0);
    tbl[19] = mkv(2, 0, 3'd0, 8'h00, 2'b00, 0, 1, 0, 8'h00, 0);
    tbl[20] = mkv(2, 0, 3'd0, 8'h00, 2'b00, 0, 1, 0, 8'h00, 0);
    tbl[21] = mkv(2, 0, 3'd0, 8'h00, 2'b00, 0, 0, 0, 8'h00, 0);

    rst_n = 1'b1;
    drive(2'b00, 1'b0, 3'd0, 8'h00, 1'b1);
    @(negedge clk);
    reset_mid_cycle("reset_init");

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].valid, tbl[i].write, tbl[i].sel, tbl[i].wd, 1'b1);
      chk($sformatf("tbl%0d_ready", i), {30'd0, o_req_ready}, {30'd0, tbl[i].e_ready});
      chk($sformatf("tbl%0d_we", i), {31'd0, o_bank_we}, {31'd0, tbl[i].e_we});
      if (tbl[i].e_rv) chk_rsp($sformatf("tbl%0d", i), tbl[i].e_id, tbl[i].e_data, tbl[i].e_err);
      else chk($sformatf("tbl%0d_rv", i), {31'd0, o_rsp_valid}, 0);
    end

    // Backpressure: response held for three cycles, CMD stalls, next request waits.
    we_base = we_count;
    step(2'b10, 1'b1, 3'd1, 8'hBB, 1'b0);
    chk("bp_acc_ready", {30'd0, o_req_ready}, 2'b10);
    step(2'b01, 1'b0, 3'd1, 8'h00, 1'b0);
    chk("bp_adv_ready", {30'd0, o_req_ready}, 2'b01);
    chk("bp_adv_we", {31'd0, o_bank_we}, 1);
    for (int i = 0; i < 3; i++) begin
      step(2'b10, 1'b0, 3'd3, 8'h00, 1'b0);
      chk($sformatf("bp_hold%0d_ready", i), {30'd0, o_req_ready}, 0);
      chk($sformatf("bp_hold%0d_we", i), {31'd0, o_bank_we}, 0);
      chk_rsp($sformatf("bp_hold%0d", i), 1'b1, 8'h00, 1'b0);
    end
    step(2'b10, 1'b0, 3'd3, 8'h00, 1'b1);
    chk("bp_release_ready", {30'd0, o_req_ready}, 2'b10);
    chk_rsp("bp_release", 1'b1, 8'h00, 1'b0);
    step(2'b00, 1'b0, 3'd0, 8'h00, 1'b1);
    chk_rsp("bp_readback", 1'b0, 8'hBB, 1'b0);
    step(2'b00, 1'b0, 3'd0, 8'h00, 1'b1);
    chk_rsp("bp_next", 1'b1, 8'h00, 1'b0);
    step(2'b00, 1'b0, 3'd0, 8'h00, 1'b1);
    chk("bp_empty_rv", {31'd0, o_rsp_valid}, 0);
    chk("bp_we_pulses", we_count - we_base, 1);

    // Contention from a fresh reset: pointer starts at client 1, so client 0 wins first.
    reset_mid_cycle("reset_contention");
`ifdef REGBANK_ARB_RR_EN
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_id = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 8; i++) begin
      if (i < 6) step(2'b11, 1'b0, 3'd2, 8'h00, 1'b1);
      else step(2'b00, 1'b0, 3'd0, 8'h00, 1'b1);
      if (i < 6) begin
        exp_rdy = exp_id[i] ? 2'b10 : 2'b01;
        chk($sformatf("cont%0d_ready", i), {30'd0, o_req_ready}, {30'd0, exp_rdy});
      end
      if (i >= 2) chk_rsp($sformatf("cont%0d", i), exp_id[i-2], 8'hAA, 1'b0);
    end

    // Reset with a write stalled in CMD behind a full response register.
    step(2'b00, 1'b0, 3'd0, 8'h00, 1'b1);
    we_base = we_count;
    step(2'b01, 1'b1, 3'd4, 8'h11, 1'b0);
    step(2'b01, 1'b1, 3'd5, 8'h22, 1'b0);
    chk("drop_first_we", {31'd0, o_bank_we}, 1);
    step(2'b00, 1'b0, 3'd0, 8'h00, 1'b0);
    chk("drop_stall_we", {31'd0, o_bank_we}, 0);
    chk("drop_stall_rv", {31'd0, o_rsp_valid}, 1);
    reset_mid_cycle("reset_drop");
    for (int i = 0; i < 4; i++) begin
      step(2'b00, 1'b0, 3'd0, 8'h00, 1'b1);
      chk($sformatf("drop%0d_rv", i), {31'd0, o_rsp_valid}, 0);
      chk($sformatf("drop%0d_we", i), {31'd0, o_bank_we}, 0);
    end
    chk("drop_we_pulses", we_count - we_base, 1);
    chk("drop_bank5", {24'd0, bank[5]}, 0);
    chk("drop_bank4", {24'd0, bank[4]}, 32'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
